// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, glitch-start rejection, framing error flag.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra parity_err output.
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge on rx_s
  // S_START  | timing to start-bit midpoint, rejects glitches
  // S_DATA   | sampling 8 data bits, LSB first
  // S_PARITY | sampling the even-parity bit (parity build only)
  // S_STOP   | sampling stop bit, publishing the byte
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] clk_cnt, cnt_nx;
  logic [2:0]       bit_idx, idx_nx;
  logic [7:0]       shift_reg, shift_nx;
  logic             rx_meta, rx_s, rx_prev;
  logic             done;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      clk_cnt   <= cnt_nx;
      bit_idx   <= idx_nx;
      shift_reg <= shift_nx;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = clk_cnt;
    idx_nx   = bit_idx;
    shift_nx = shift_reg;
    done     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx   = par_bit;
`endif
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        // rx_prev gate keeps a held-low line (break) from re-triggering
        if (rx_prev && !rx_s) state_nx = S_START;
      end
      S_START: begin
        if (clk_cnt == HALF_TC) begin
          cnt_nx   = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == BIT_TC) begin
          cnt_nx            = '0;
          shift_nx[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end else begin
            idx_nx = bit_idx + 3'd1;
          end
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == BIT_TC) begin
          cnt_nx   = '0;
          par_nx   = rx_s;
          state_nx = S_STOP;
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == BIT_TC) begin
          cnt_nx   = '0;
          done     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= 8'h00;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      valid <= done;
      if (done) begin
        data_out   <= shift_reg;
        frame_err  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_bit ^ (^shift_reg);
`endif
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames, back-to-back, framing error, glitch, mid-frame reset.
module tb_uart_rx;
  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;
  int vcount = 0;
  int v0;
  logic [7:0] rx_log[$];

  uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      rx_log.push_back(data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par_b, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) rx = 1'b0;
`endif
    send_bit(stop_b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    send_raw(b, ^b, stop_b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // single good frame
    v0 = vcount;
    send_frame(8'h55, 1'b1);
    chk("t1_vcount", vcount - v0, 1);
    chk("t1_data", data_out, 8'h55);
    chk("t1_ferr", frame_err, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // back-to-back frames, no idle gap
    v0 = vcount;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    chk("t2_vcount", vcount - v0, 2);
    chk("t2_byte0", rx_log[v0], 8'hA3);
    chk("t2_byte1", rx_log[v0 + 1], 8'h00);

    // bad stop bit then line held low (break)
    v0 = vcount;
    send_frame(8'h3C, 1'b0);
    chk("t3_vcount", vcount - v0, 1);
    chk("t3_data", data_out, 8'h3C);
    chk("t3_ferr", frame_err, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    chk("t3_break_busy", busy, 1'b0);
    chk("t3_break_novalid", vcount - v0, 1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t3_ferr_hold", frame_err, 1'b1);
    send_frame(8'h81, 1'b1);
    chk("t3_good_data", data_out, 8'h81);
    chk("t3_good_ferr", frame_err, 1'b0);
    repeat (CPB) @(negedge clk);

    // short low glitch
    v0 = vcount;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    chk("t4_busy_hi", busy, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("t4_busy_lo", busy, 1'b0);
    chk("t4_novalid", vcount - v0, 0);
    chk("t4_data_hold", data_out, 8'h81);

    // reset in the middle of data bit 4 of 8'hFF
    v0 = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    chk("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_data", data_out, 8'h00);
    chk("t5_valid", valid, 1'b0);
    chk("t5_ferr", frame_err, 1'b0);
    chk("t5_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    chk("t5_novalid", vcount - v0, 0);
    send_frame(8'h12, 1'b1);
    chk("t5_vcount", vcount - v0, 1);
    chk("t5_after_data", data_out, 8'h12);
    chk("t5_after_ferr", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
    repeat (CPB) @(negedge clk);
    send_raw(8'h07, 1'b1, 1'b1);
    chk("t6_data_p1", data_out, 8'h07);
    chk("t6_perr_ok", parity_err, 1'b0);
    repeat (CPB) @(negedge clk);
    send_raw(8'h07, 1'b0, 1'b1);
    chk("t6_perr_bad", parity_err, 1'b1);
    chk("t6_ferr", frame_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
